// File: rtl/dfr0520_pkg.sv
// Shared encodings and helpers for the DFR0520 wiper sequencer.
package dfr0520_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_LOW  = 3'd2,
    ST_WAIT_HIGH = 3'd3,
    ST_GAP       = 3'd4,
    ST_STEP_WAIT = 3'd5
  } state_t;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_SHDN  = 2'b10;

  localparam logic [1:0] SEL_NONE  = 2'b00;
  localparam logic [1:0] SEL_POT0  = 2'b01;
  localparam logic [1:0] SEL_POT1  = 2'b10;

  localparam logic [7:0] RESET_WIPER = 8'h80;

  // Channel number to the driver's one-hot select field.
  function automatic logic [1:0] sel_for(input logic ch);
    return ch ? SEL_POT1 : SEL_POT0;
  endfunction

  // One LSB toward the target; never overshoots and never wraps.
  function automatic logic [7:0] step_toward(input logic [7:0] cur,
                                             input logic [7:0] tgt);
    if (tgt > cur)
      return cur + 8'd1;
    else if (tgt < cur)
      return cur - 8'd1;
    else
      return cur;
  endfunction

endpackage

// File: rtl/dfr0520_wiper_sequencer_step_timer.sv
// Loadable down-counter shared by the GAP, STEP_WAIT and CS-timeout phases.
// done is high while the count sits at zero; a load wins over counting.
module dfr0520_step_timer #(
  parameter int W = 16
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done
);

  logic [W-1:0] count;

  // Reload on request, otherwise count down and park at zero.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_value;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign done = (count == '0);

endmodule

// File: rtl/dfr0520_wiper_sequencer.sv
// Command sequencer in front of the DFR0520 SPI driver: accepts wiper
// requests, issues one-cycle load strobes, follows the driver's CS to
// detect transfer completion, and keeps a shadow copy of both wipers.
module dfr0520_wiper_sequencer
  import dfr0520_pkg::*;
#(
  parameter int STEP_INTERVAL = 1000,
  parameter int GAP_CYCLES    = 2,
  parameter int CS_TIMEOUT    = 16
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_ch,
  input  logic [7:0] req_target,
  input  logic       req_ramp,
  input  logic       req_shutdown,
  output logic       spi_en,
  output logic [1:0] spi_cmd,
  output logic [1:0] spi_sel,
  output logic [7:0] spi_data,
  input  logic       spi_cs,
  output logic [7:0] wiper0,
  output logic [7:0] wiper1,
  output logic       busy,
  output logic       err_timeout
);

  // Wide enough for every value the timer is ever loaded with.
  localparam int TIMER_W = $clog2(STEP_INTERVAL + GAP_CYCLES + CS_TIMEOUT + 2);

  // Timer loads are one less than the cycle count because the load edge
  // itself opens the first counted cycle. The step load is measured so the
  // next strobe lands STEP_INTERVAL cycles after the first CS-high cycle,
  // with the GAP cycles and the GAP->STEP_WAIT hand-off inside that span.
  localparam int TO_RAW   = CS_TIMEOUT - 1;
  localparam int GAP_RAW  = GAP_CYCLES - 1;
  localparam int STEP_RAW = STEP_INTERVAL - GAP_CYCLES - 2;

  localparam logic [TIMER_W-1:0] TO_LOAD   = TIMER_W'((TO_RAW   > 0) ? TO_RAW   : 0);
  localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'((GAP_RAW  > 0) ? GAP_RAW  : 0);
  localparam logic [TIMER_W-1:0] STEP_LOAD = TIMER_W'((STEP_RAW > 0) ? STEP_RAW : 0);

  state_t              state;
  logic                cur_ch;
  logic [7:0]          cur_target;
  logic                cur_ramp;

  logic                accept;
  logic [7:0]          req_shadow;
  logic                req_noop;
  logic [7:0]          cur_shadow;
  logic                more_steps;

  logic                tmr_load;
  logic [TIMER_W-1:0]  tmr_value;
  logic                tmr_done;

  // A strobe is only ever launched from IDLE while the driver is idle.
  assign req_ready  = (state == ST_IDLE) && spi_cs;
  assign busy       = (state != ST_IDLE);
  assign accept     = req_valid && req_ready;

  assign req_shadow = req_ch ? wiper1 : wiper0;
  assign req_noop   = req_ramp && !req_shutdown && (req_target == req_shadow);
  assign cur_shadow = cur_ch ? wiper1 : wiper0;
  assign more_steps = cur_ramp && (cur_shadow != cur_target);

  // Timer reloads coincide with the FSM edges that open each timed phase.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state)
      ST_IDLE: begin
        if (accept && !req_noop) begin
          tmr_load  = 1'b1;
          tmr_value = TO_LOAD;
        end
      end
      ST_WAIT_HIGH: begin
        if (spi_cs) begin
          tmr_load  = 1'b1;
          tmr_value = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (tmr_done && more_steps) begin
          tmr_load  = 1'b1;
          tmr_value = STEP_LOAD;
        end
      end
      ST_STEP_WAIT: begin
        if (tmr_done) begin
          tmr_load  = 1'b1;
          tmr_value = TO_LOAD;
        end
      end
      default: begin
        tmr_load  = 1'b0;
        tmr_value = '0;
      end
    endcase
  end

  dfr0520_step_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clk_in     (clk_in),
    .rst        (rst),
    .load       (tmr_load),
    .load_value (tmr_value),
    .done       (tmr_done)
  );

  // Request payload captured on accept; only read while the FSM is busy.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      cur_ch     <= req_ch;
      cur_target <= req_target;
    end
  end

  // Sequencer FSM with registered strobe, command word and shadow wipers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cur_ramp    <= 1'b0;
      spi_en      <= 1'b0;
      spi_cmd     <= CMD_NONE;
      spi_sel     <= SEL_NONE;
      spi_data    <= 8'h00;
      wiper0      <= RESET_WIPER;
      wiper1      <= RESET_WIPER;
      err_timeout <= 1'b0;
    end else begin
      spi_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cur_ramp <= req_ramp && !req_shutdown;
            if (!req_noop) begin
              spi_en  <= 1'b1;
              spi_sel <= sel_for(req_ch);
              if (req_shutdown) begin
                spi_cmd  <= CMD_SHDN;
                spi_data <= 8'h00;
              end else begin
                spi_cmd  <= CMD_WRITE;
                spi_data <= req_ramp ? step_toward(req_shadow, req_target)
                                     : req_target;
              end
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT_LOW;
        end
        ST_WAIT_LOW: begin
          if (!spi_cs) begin
            state <= ST_WAIT_HIGH;
          end else if (tmr_done) begin
            // Driver never started the frame: flag it and drop any ramp.
            err_timeout <= 1'b1;
            cur_ramp    <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        ST_WAIT_HIGH: begin
          if (spi_cs) begin
            if (spi_cmd == CMD_WRITE) begin
              if (cur_ch)
                wiper1 <= spi_data;
              else
                wiper0 <= spi_data;
            end
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tmr_done)
            state <= more_steps ? ST_STEP_WAIT : ST_IDLE;
        end
        ST_STEP_WAIT: begin
          if (tmr_done) begin
            spi_en   <= 1'b1;
            spi_data <= step_toward(cur_shadow, cur_target);
            state    <= ST_ISSUE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dfr0520_wiper_sequencer.sv
// Scoreboard bench for the DFR0520 wiper sequencer with a simple SPI
// driver stand-in that pulls CS low for a fixed frame after each strobe.
module tb_dfr0520_wiper_sequencer;

  localparam int STEP_INTERVAL = 40;
  localparam int GAP_CYCLES    = 2;
  localparam int CS_TIMEOUT    = 16;
  localparam int LOW_LEN       = 17;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_ch = 1'b0;
  logic [7:0] req_target = 8'h00;
  logic       req_ramp = 1'b0;
  logic       req_shutdown = 1'b0;
  logic       spi_en;
  logic [1:0] spi_cmd;
  logic [1:0] spi_sel;
  logic [7:0] spi_data;
  logic       spi_cs;
  logic [7:0] wiper0;
  logic [7:0] wiper1;
  logic       busy;
  logic       err_timeout;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  dfr0520_wiper_sequencer #(
    .STEP_INTERVAL (STEP_INTERVAL),
    .GAP_CYCLES    (GAP_CYCLES),
    .CS_TIMEOUT    (CS_TIMEOUT)
  ) dut (
    .clk_in       (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_ch       (req_ch),
    .req_target   (req_target),
    .req_ramp     (req_ramp),
    .req_shutdown (req_shutdown),
    .spi_en       (spi_en),
    .spi_cmd      (spi_cmd),
    .spi_sel      (spi_sel),
    .spi_data     (spi_data),
    .spi_cs       (spi_cs),
    .wiper0       (wiper0),
    .wiper1       (wiper1),
    .busy         (busy),
    .err_timeout  (err_timeout)
  );

  // Driver stand-in: CS low from 3 cycles after the strobe for LOW_LEN cycles.
  bit drv_present = 1'b1;
  int t = 0;
  always @(posedge clk) begin
    if (t == 0) begin
      if (spi_en && drv_present) t <= 1;
    end else if (t == 2 + LOW_LEN) begin
      t <= 0;
    end else begin
      t <= t + 1;
    end
  end
  assign spi_cs = !(t >= 3);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    checks++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Expected strobe plus the wiper values that must hold after its CS rise.
  typedef struct {
    logic [1:0] cmd;
    logic [1:0] sel;
    logic [7:0] data;
    logic [7:0] w0;
    logic [7:0] w1;
    bit         step;
    bit         timeout;
  } item_t;

  item_t exp_q[$];
  logic [7:0] m_w [2];

  // Reference model: expand a request into the list of SPI words it implies.
  task automatic model_push(input bit ch, input logic [7:0] tgt, input bit ramp,
                            input bit shdn, input bit no_drv);
    item_t it;
    int    cur;
    bit    first;
    it.sel = ch ? 2'b10 : 2'b01;
    it.step = 1'b0;
    it.timeout = no_drv;
    if (shdn) begin
      it.cmd = 2'b10; it.data = 8'h00;
      it.w0 = m_w[0]; it.w1 = m_w[1];
      exp_q.push_back(it);
    end else if (!ramp) begin
      it.cmd = 2'b01; it.data = tgt;
      if (!no_drv) m_w[ch] = tgt;
      it.w0 = m_w[0]; it.w1 = m_w[1];
      exp_q.push_back(it);
    end else begin
      first = 1'b1;
      while (m_w[ch] != tgt) begin
        cur = int'(m_w[ch]);
        cur = (int'(tgt) > cur) ? cur + 1 : cur - 1;
        it.cmd = 2'b01; it.data = 8'(cur);
        it.step = !first;
        if (!no_drv) m_w[ch] = 8'(cur);
        it.w0 = m_w[0]; it.w1 = m_w[1];
        exp_q.push_back(it);
        first = 1'b0;
        if (no_drv) break;
      end
    end
  endtask

  // Monitor: compares every strobe against the queue head, then the
  // shadow wipers after the matching CS rise and any timeout latency.
  int    cyc = 0;
  int    last_rise = 0;
  bit    pend = 0;
  int    pend_cnt = 0;
  bit    chk_w_next = 0;
  bit    to_watch = 0;
  int    to_cnt = 0;
  logic  cs_prev = 1'b1;
  item_t mon_it;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      pend = 0; chk_w_next = 0; to_watch = 0;
    end else begin
      if (chk_w_next) begin
        chk("wiper0_after_xfer", wiper0, mon_it.w0);
        chk("wiper1_after_xfer", wiper1, mon_it.w1);
        chk_w_next = 0;
      end
      if (pend) begin
        pend_cnt++;
        if (spi_cs && !cs_prev) begin
          chk_w_next = 1; pend = 0; last_rise = cyc;
        end else if (pend_cnt > 500) begin
          fail("cs_rise_wait"); pend = 0;
        end
      end
      if (to_watch) begin
        to_cnt++;
        if (err_timeout) begin
          chk("timeout_latency", to_cnt, CS_TIMEOUT);
          to_watch = 0;
        end else if (to_cnt > 200) begin
          fail("timeout_wait"); to_watch = 0;
        end
      end
      if (spi_en) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_strobe");
        end else begin
          mon_it = exp_q.pop_front();
          chk("spi_cmd", spi_cmd, mon_it.cmd);
          chk("spi_sel", spi_sel, mon_it.sel);
          chk("spi_data", spi_data, mon_it.data);
          if (mon_it.step) chk("step_interval", cyc - last_rise, STEP_INTERVAL);
          if (mon_it.timeout) begin
            chk("err_before_timeout", err_timeout, 0);
            to_watch = 1; to_cnt = 0;
          end else begin
            pend = 1; pend_cnt = 0;
          end
        end
      end
    end
    cs_prev = spi_cs;
  end

  // Issue one request from a negedge and wait for the sequencer to go idle.
  task automatic do_req(input bit ch, input logic [7:0] tgt, input bit ramp,
                        input bit shdn);
    int g;
    bit noop;
    g = 0;
    while (!req_ready && g < 500) begin @(negedge clk); g++; end
    if (!req_ready) begin fail("ready_wait"); return; end
    noop = ramp && !shdn && (m_w[ch] == tgt);
    model_push(ch, tgt, ramp, shdn, !drv_present);
    req_ch = ch; req_target = tgt; req_ramp = ramp; req_shutdown = shdn;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (noop) begin
      chk("noop_busy", busy, 0);
      @(negedge clk);
      chk("noop_ready", req_ready, 1);
    end
    g = 0;
    while (busy && g < 3000) begin @(negedge clk); g++; end
    if (busy) fail("busy_wait");
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   ch;
    int   tg;
    bit   rmp;
    bit   sd;
    int   g;
    m_w[0] = 8'h80; m_w[1] = 8'h80;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_spi_en", spi_en, 0);
    chk("rst_spi_cmd", spi_cmd, 0);
    chk("rst_spi_sel", spi_sel, 0);
    chk("rst_spi_data", spi_data, 0);
    chk("rst_wiper0", wiper0, 8'h80);
    chk("rst_wiper1", wiper1, 8'h80);
    chk("rst_err", err_timeout, 0);

    do_req(1'b0, 8'h3C, 1'b0, 1'b0);
    do_req(1'b1, 8'h83, 1'b1, 1'b0);
    do_req(1'b1, 8'h83, 1'b1, 1'b0);
    do_req(1'b1, 8'h83, 1'b0, 1'b0);
    do_req(1'b0, 8'h10, 1'b0, 1'b0);
    do_req(1'b0, 8'h99, 1'b0, 1'b1);
    do_req(1'b0, 8'hFE, 1'b0, 1'b0);
    do_req(1'b0, 8'hFF, 1'b1, 1'b0);
    do_req(1'b0, 8'hFF, 1'b1, 1'b0);
    do_req(1'b1, 8'h01, 1'b0, 1'b0);
    do_req(1'b1, 8'h00, 1'b1, 1'b0);

    for (int i = 0; i < 20; i++) begin
      ch  = int'($urandom_range(1, 0));
      sd  = ($urandom_range(5, 0) == 0);
      rmp = $urandom_range(1, 0) == 1;
      if (rmp) begin
        tg = int'(m_w[ch]) + int'($urandom_range(6, 0)) - 3;
        if (tg < 0) tg = 0;
        if (tg > 255) tg = 255;
      end else begin
        tg = int'($urandom_range(255, 0));
      end
      do_req(ch[0], 8'(tg), rmp, sd);
    end

    drv_present = 1'b0;
    do_req(1'b1, 8'h55, 1'b0, 1'b0);
    drv_present = 1'b1;
    chk("timeout_wiper1_kept", wiper1, m_w[1]);
    chk("timeout_idle", busy, 0);
    do_req(1'b0, 8'h40, 1'b0, 1'b0);
    do_req(1'b1, 8'h21, 1'b0, 1'b0);
    chk("err_sticky", err_timeout, 1);

    // Ramp, then reset while the first frame is in flight.
    model_push(1'b0, 8'h43, 1'b1, 1'b0, 1'b0);
    req_ch = 1'b0; req_target = 8'h43; req_ramp = 1'b1; req_shutdown = 1'b0;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    g = 0;
    while (spi_cs && g < 100) begin @(negedge clk); g++; end
    if (spi_cs) fail("cs_low_wait");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_spi_en", spi_en, 0);
    chk("midrst_spi_cmd", spi_cmd, 0);
    chk("midrst_spi_sel", spi_sel, 0);
    chk("midrst_spi_data", spi_data, 0);
    chk("midrst_wiper0", wiper0, 8'h80);
    chk("midrst_wiper1", wiper1, 8'h80);
    chk("midrst_busy", busy, 0);
    chk("midrst_err", err_timeout, 0);
    m_w[0] = 8'h80; m_w[1] = 8'h80;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (80) @(negedge clk);
    chk("post_rst_wiper0", wiper0, 8'h80);
    chk("post_rst_wiper1", wiper1, 8'h80);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ready", req_ready, 1);
    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
